// File: rtl/key_debouncer.sv
// Push-button conditioner. It synchronises the raw key, debounces it over CNT_MAX cycles,
// and emits one-cycle press, release and long-press pulses, a stable level and a press count.
module key_debouncer #(
  parameter logic [31:0] CNT_MAX      = 32'd1_000_000,
  parameter logic [31:0] LONG_MAX     = 32'd100_000_000,
  parameter logic        ACTIVE_LEVEL = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       key_in,
  output logic       key_level,
  output logic       press_pulse,
  output logic       release_pulse,
  output logic       long_pulse,
  output logic [7:0] press_cnt
);

  typedef enum logic [1:0] {IDLE, PRESS_DB, HELD, RELEASE_DB} state_t;

  state_t      state;
  logic        sync1;
  logic        sync2;
  logic        key_s;
  logic [31:0] db_cnt;
  logic [31:0] hold_cnt;

  // Two-flop synchroniser. It resets to the released level, so leaving reset never looks like a press.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1 <= ~ACTIVE_LEVEL;
      sync2 <= ~ACTIVE_LEVEL;
    end else begin
      sync1 <= key_in;
      sync2 <= sync1;
    end
  end

  assign key_s = (sync2 == ACTIVE_LEVEL);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= IDLE;
      db_cnt        <= '0;
      hold_cnt      <= '0;
      key_level     <= 1'b0;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      long_pulse    <= 1'b0;
      press_cnt     <= '0;
    end else begin
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      long_pulse    <= 1'b0;

      // hold_cnt keeps running through release bounces. Saturation limits long_pulse to one per press.
      if ((state == HELD || state == RELEASE_DB) && hold_cnt != LONG_MAX - 32'd1) begin
        hold_cnt <= hold_cnt + 32'd1;
        if (hold_cnt == LONG_MAX - 32'd2)
          long_pulse <= 1'b1;
      end

      case (state)
        IDLE: begin
          if (key_s) begin
            state  <= PRESS_DB;
            db_cnt <= '0;
          end
        end
        PRESS_DB: begin
          if (!key_s) begin
            state <= IDLE;
          end else if (db_cnt == CNT_MAX - 32'd1) begin
            state       <= HELD;
            press_pulse <= 1'b1;
            key_level   <= 1'b1;
            press_cnt   <= press_cnt + 8'd1;
            hold_cnt    <= '0;
          end else begin
            db_cnt <= db_cnt + 32'd1;
          end
        end
        HELD: begin
          if (!key_s) begin
            state  <= RELEASE_DB;
            db_cnt <= '0;
          end
        end
        RELEASE_DB: begin
          if (key_s) begin
            state <= HELD;
          end else if (db_cnt == CNT_MAX - 32'd1) begin
            state         <= IDLE;
            release_pulse <= 1'b1;
            key_level     <= 1'b0;
          end else begin
            db_cnt <= db_cnt + 32'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
